// File: rtl/dcache_controller.sv
// dcache_controller
//   Direct-mapped, write-back data cache: 8 blocks x 4 bytes, 3-bit tags.
//   Address split: tag = ADDRESS[7:5], index = ADDRESS[4:2], offset = ADDRESS[1:0].
//   Hits resolve combinationally. A miss stalls the CPU (BUSYWAIT) while the
//   controller writes back a dirty victim, fetches the block and refills it.
//
// Ports
//   CLK, RESETN            clock, asynchronous active-low reset
//   READ, WRITE            CPU load/store request (WRITE wins if both high)
//   ADDRESS, WRITEDATA     CPU byte address / store byte
//   READDATA, BUSYWAIT     load byte / CPU stall
//   MEM_READ, MEM_WRITE    block fetch / write-back strobes
//   MEM_ADDRESS            block address {tag,index}
//   MEM_WRITEDATA          write-back block (byte 0 in [7:0])
//   MEM_READDATA           fetched block (byte 0 in [7:0])
//   MEM_BUSYWAIT           memory busy
//   HIT_COUNT, MISS_COUNT  saturating statistics counters
//
// Build option
//   CACHE_STATS_EN  when defined, builds the hit/miss counters; otherwise
//                   HIT_COUNT and MISS_COUNT are tied to zero.
module dcache_controller (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT,
    output logic [7:0]  HIT_COUNT,
    output logic [7:0]  MISS_COUNT
);

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

    state_t      state_q, state_d;
    logic        first_q, first_d;    // first cycle of WRITEBACK/FETCH
    logic        refill_q, refill_d;  // IDLE cycle right after UPDATE
    logic [7:0]  valid_q, dirty_q;
    logic [2:0]  tag_q  [8];
    logic [31:0] data_q [8];

    logic [2:0]  a_tag, a_idx;
    logic [1:0]  a_off;
    logic        req, hit, mem_done;
    logic        wr_hit, hit_evt, miss_evt;

    assign a_tag = ADDRESS[7:5];
    assign a_idx = ADDRESS[4:2];
    assign a_off = ADDRESS[1:0];
    assign req   = READ | WRITE;
    assign hit   = valid_q[a_idx] && (tag_q[a_idx] == a_tag);

    // Busy is ignored in the entry cycle so a memory that raises busy one
    // cycle late is not mistaken for an instant completion.
    assign mem_done = !first_q && !MEM_BUSYWAIT;

    always_comb begin
        state_d       = state_q;
        first_d       = 1'b0;
        refill_d      = 1'b0;
        BUSYWAIT      = 1'b0;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = '0;
        MEM_WRITEDATA = '0;
        READDATA      = '0;
        wr_hit        = 1'b0;
        hit_evt       = 1'b0;
        miss_evt      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        // The re-evaluation after a refill is the tail of a
                        // miss, not a fresh hit.
                        hit_evt = !refill_q;
                        if (WRITE) wr_hit = 1'b1;
                        else       READDATA = data_q[a_idx][{a_off, 3'b000} +: 8];
                    end else begin
                        BUSYWAIT = 1'b1;
                        miss_evt = 1'b1;
                        first_d  = 1'b1;
                        state_d  = (valid_q[a_idx] && dirty_q[a_idx]) ? WRITEBACK : FETCH;
                    end
                end
            end
            WRITEBACK: begin
                BUSYWAIT      = 1'b1;
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {tag_q[a_idx], a_idx};
                MEM_WRITEDATA = data_q[a_idx];
                if (mem_done) begin
                    state_d = FETCH;
                    first_d = 1'b1;
                end
            end
            FETCH: begin
                BUSYWAIT    = 1'b1;
                MEM_READ    = 1'b1;
                MEM_ADDRESS = ADDRESS[7:2];
                if (mem_done) state_d = UPDATE;
            end
            UPDATE: begin
                BUSYWAIT = 1'b1;
                refill_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q  <= IDLE;
            first_q  <= 1'b0;
            refill_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            first_q  <= first_d;
            refill_q <= refill_d;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int i = 0; i < 8; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else if (wr_hit) begin
            data_q[a_idx][{a_off, 3'b000} +: 8] <= WRITEDATA;
            dirty_q[a_idx]                      <= 1'b1;
        end else if (state_q == UPDATE) begin
            data_q[a_idx]  <= MEM_READDATA;
            tag_q[a_idx]   <= a_tag;
            valid_q[a_idx] <= 1'b1;
            dirty_q[a_idx] <= 1'b0;
        end
    end

`ifdef CACHE_STATS_EN
    logic [7:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_evt && hit_cnt_q != 8'hFF)   hit_cnt_q  <= hit_cnt_q + 8'd1;
            if (miss_evt && miss_cnt_q != 8'hFF) miss_cnt_q <= miss_cnt_q + 8'd1;
        end
    end

    assign HIT_COUNT  = hit_cnt_q;
    assign MISS_COUNT = miss_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = hit_evt ^ miss_evt;
    assign HIT_COUNT    = '0;
    assign MISS_COUNT   = '0;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: directed scenarios plus a
// randomized load/store stream checked against a behavioural cache model.
module tb_dcache_controller;

    logic        CLK, RESETN, READ, WRITE;
    logic [7:0]  ADDRESS, WRITEDATA, READDATA;
    logic        BUSYWAIT, MEM_READ, MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA, MEM_READDATA;
    logic        MEM_BUSYWAIT;
    logic [7:0]  HIT_COUNT, MISS_COUNT;

    dcache_controller dut (
        .CLK(CLK), .RESETN(RESETN), .READ(READ), .WRITE(WRITE),
        .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
        .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT),
        .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Memory backing store driven by the responder, and the model's copy.
    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    int          mem_lat = 1;

    // Behavioural cache model: which block lives at each index, and its bytes.
    bit          m_valid [8];
    bit          m_dirty [8];
    int          m_blk   [8];   // block address {tag,index} held
    logic [31:0] m_data  [8];
    int          exp_hits, exp_miss;

    typedef struct {
        bit          miss;
        bit          strobe_at_req;
        bit          wb;
        logic [5:0]  wb_addr;
        logic [31:0] wb_data;
        logic [5:0]  rd_addr;
        int          rd_cycles;
        int          wr_cycles;
        int          gaps;
        logic [7:0]  rdata;
        bit          timeout;
    } obs_t;

    // Memory responder: on a new strobe, holds busy for mem_lat cycles
    // (raised one cycle after the strobe appears), then completes.
    initial begin
        bit active, act_wr;
        int cnt;
        active = 0; act_wr = 0; cnt = 0;
        MEM_BUSYWAIT = 1'b0; MEM_READDATA = '0;
        forever begin
            @(posedge CLK); #1;
            if (!RESETN) begin
                active = 0; MEM_BUSYWAIT = 1'b0;
                continue;
            end
            if (active && !(act_wr ? MEM_WRITE : MEM_READ)) active = 0;
            if (!active && (MEM_READ || MEM_WRITE)) begin
                active = 1; act_wr = MEM_WRITE; cnt = mem_lat + 1;
            end
            if (active && cnt > 0) begin
                cnt--;
                MEM_BUSYWAIT = (cnt > 0);
                if (cnt == 0) begin
                    if (act_wr) mem[MEM_ADDRESS] = MEM_WRITEDATA;
                    else        MEM_READDATA = mem[MEM_ADDRESS];
                end
            end
        end
    end

    function automatic int lat_cycles();
        return (mem_lat < 1 ? 1 : mem_lat) + 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 0; m_dirty[i] = 0;
        end
        exp_hits = 0; exp_miss = 0;
    endtask

    // Predicts what one access should look like and advances the model.
    task automatic model_access(input bit wr, input logic [7:0] a,
                                input logic [7:0] wd, output obs_t e);
        int idx, blk, off;
        idx = int'(a[4:2]); blk = int'(a[7:2]); off = int'(a[1:0]);
        e = '{default: 0};
        if (m_valid[idx] && m_blk[idx] == blk) begin
            if (exp_hits < 255) exp_hits++;
        end else begin
            e.miss = 1;
            if (exp_miss < 255) exp_miss++;
            if (m_valid[idx] && m_dirty[idx]) begin
                e.wb        = 1;
                e.wb_addr   = 6'(m_blk[idx]);
                e.wb_data   = m_data[idx];
                e.wr_cycles = lat_cycles();
                ref_mem[m_blk[idx]] = m_data[idx];
            end
            e.rd_addr   = 6'(blk);
            e.rd_cycles = lat_cycles();
            e.gaps      = 1;
            m_valid[idx] = 1; m_dirty[idx] = 0;
            m_blk[idx]   = blk; m_data[idx] = ref_mem[blk];
        end
        if (wr) begin
            m_data[idx][off*8 +: 8] = wd;
            m_dirty[idx] = 1;
        end else begin
            e.rdata = m_data[idx][off*8 +: 8];
        end
    endtask

    // Drives one CPU access and records what the DUT did.
    task automatic cpu_access(input bit wr, input logic [7:0] a,
                              input logic [7:0] wd, output obs_t o);
        int n;
        o = '{default: 0};
        n = 0;
        @(negedge CLK);
        READ = !wr; WRITE = wr; ADDRESS = a; WRITEDATA = wd;
        #1;
        o.miss          = BUSYWAIT;
        o.strobe_at_req = MEM_READ | MEM_WRITE;
        while (BUSYWAIT && n < 200) begin
            @(negedge CLK); #1; n++;
            if (MEM_WRITE) begin
                if (!o.wb) begin
                    o.wb = 1; o.wb_addr = MEM_ADDRESS; o.wb_data = MEM_WRITEDATA;
                end
                o.wr_cycles++;
            end else if (MEM_READ) begin
                o.rd_addr = MEM_ADDRESS; o.rd_cycles++;
            end else if (BUSYWAIT) begin
                o.gaps++;
            end
        end
        o.timeout = BUSYWAIT;
        o.rdata   = READDATA;
        @(posedge CLK); #1;
        READ = 1'b0; WRITE = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        READ = 1'b0; WRITE = 1'b0; RESETN = 1'b0;
        repeat (2) @(negedge CLK);
        RESETN = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
        RESETN = 1'b0;
        repeat (2) @(negedge CLK);
        n_cmp++;
        if ({BUSYWAIT, MEM_READ, MEM_WRITE} !== 3'b000) begin
            n_err++; $display("FAIL reset_ctl: busy/rd/wr=%b want 000", {BUSYWAIT, MEM_READ, MEM_WRITE});
        end
        n_cmp++;
        if (MEM_ADDRESS !== 6'h0 || MEM_WRITEDATA !== 32'h0 || READDATA !== 8'h0) begin
            n_err++; $display("FAIL reset_data: maddr=%h mwdata=%h rdata=%h want 0", MEM_ADDRESS, MEM_WRITEDATA, READDATA);
        end
        n_cmp++;
        if (HIT_COUNT !== 8'h0 || MISS_COUNT !== 8'h0) begin
            n_err++; $display("FAIL reset_cnt: hit=%0d miss=%0d want 0", HIT_COUNT, MISS_COUNT);
        end
        RESETN = 1'b1;
        model_reset();
        @(negedge CLK);
        n_cmp++;
        if (BUSYWAIT !== 1'b0) begin
            n_err++; $display("FAIL idle_busy: got %b want 0", BUSYWAIT);
        end
    endtask

    task automatic test_directed();
        obs_t o, e;
        mem_lat = 1;
        cpu_access(0, 8'h00, 8'h00, o); model_access(0, 8'h00, 8'h00, e);
        n_cmp++;
        if (o.miss !== 1'b1 || o.wb !== 1'b0 || o.rd_addr !== 6'h00 || o.timeout) begin
            n_err++; $display("FAIL first_miss: miss=%b wb=%b addr=%h to=%b want 1 0 00 0", o.miss, o.wb, o.rd_addr, o.timeout);
        end
        n_cmp++;
        if (o.rdata !== 8'h11) begin
            n_err++; $display("FAIL first_rdata: got %h want 11", o.rdata);
        end
        cpu_access(0, 8'h03, 8'h00, o); model_access(0, 8'h03, 8'h00, e);
        n_cmp++;
        if (o.miss !== 1'b0 || o.strobe_at_req !== 1'b0 || o.rdata !== 8'h44) begin
            n_err++; $display("FAIL read_hit: busy=%b strobe=%b rdata=%h want 0 0 44", o.miss, o.strobe_at_req, o.rdata);
        end
        cpu_access(1, 8'h01, 8'hAA, o); model_access(1, 8'h01, 8'hAA, e);
        n_cmp++;
        if (o.miss !== 1'b0 || o.strobe_at_req !== 1'b0) begin
            n_err++; $display("FAIL write_hit: busy=%b strobe=%b want 0 0", o.miss, o.strobe_at_req);
        end
        cpu_access(0, 8'h21, 8'h00, o); model_access(0, 8'h21, 8'h00, e);
        n_cmp++;
        if (o.wb !== 1'b1 || o.wb_addr !== 6'h00 || o.wb_data !== 32'h4433AA11) begin
            n_err++; $display("FAIL writeback: wb=%b addr=%h data=%h want 1 00 4433aa11", o.wb, o.wb_addr, o.wb_data);
        end
        n_cmp++;
        if (o.rd_addr !== 6'h08 || o.rdata !== e.rdata) begin
            n_err++; $display("FAIL refetch: addr=%h rdata=%h want 08 %h", o.rd_addr, o.rdata, e.rdata);
        end
        n_cmp++;
        if (mem[0] !== 32'h4433AA11) begin
            n_err++; $display("FAIL mem_block0: got %h want 4433aa11", mem[0]);
        end
    endtask

    task automatic test_latency();
        obs_t o, e;
        mem_lat = 5;
        cpu_access(0, 8'h60, 8'h00, o); model_access(0, 8'h60, 8'h00, e);
        n_cmp++;
        if (o.rd_cycles !== 6 || o.gaps !== 1 || o.timeout) begin
            n_err++; $display("FAIL slow_mem: rd_cycles=%0d gaps=%0d to=%b want 6 1 0", o.rd_cycles, o.gaps, o.timeout);
        end
        n_cmp++;
        if (o.rdata !== e.rdata) begin
            n_err++; $display("FAIL slow_rdata: got %h want %h", o.rdata, e.rdata);
        end
        mem_lat = 1;
    endtask

    task automatic test_reset_midfetch();
        obs_t o, e;
        int n;
        mem_lat = 5;
        n = 0;
        @(negedge CLK);
        READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h84;
        while (!MEM_READ && n < 20) begin
            @(negedge CLK); n++;
        end
        n_cmp++;
        if (!MEM_READ) begin
            n_err++; $display("FAIL midfetch_start: MEM_READ=%b want 1", MEM_READ);
        end
        @(negedge CLK);
        RESETN = 1'b0; READ = 1'b0;
        #1;
        n_cmp++;
        if ({MEM_READ, MEM_WRITE, BUSYWAIT} !== 3'b000 || MEM_ADDRESS !== 6'h0) begin
            n_err++; $display("FAIL midfetch_reset: rd/wr/busy=%b addr=%h want 000 00", {MEM_READ, MEM_WRITE, BUSYWAIT}, MEM_ADDRESS);
        end
        repeat (2) @(negedge CLK);
        RESETN = 1'b1;
        model_reset();
        mem_lat = 1;
        cpu_access(0, 8'h00, 8'h00, o); model_access(0, 8'h00, 8'h00, e);
        n_cmp++;
        if (o.miss !== 1'b1 || o.rdata !== e.rdata) begin
            n_err++; $display("FAIL post_reset_miss: miss=%b rdata=%h want 1 %h", o.miss, o.rdata, e.rdata);
        end
    endtask

    task automatic test_random();
        obs_t o, e;
        bit wr;
        logic [7:0] a, wd;
        for (int i = 0; i < 200; i++) begin
            wr      = 1'($urandom % 2);
            a       = 8'($urandom);
            wd      = 8'($urandom);
            mem_lat = $urandom_range(0, 3);
            cpu_access(wr, a, wd, o); model_access(wr, a, wd, e);
            n_cmp++;
            if (o.miss !== e.miss || o.wb !== e.wb || o.timeout) begin
                n_err++; $display("FAIL rnd_kind #%0d a=%h: miss=%b wb=%b to=%b want %b %b 0", i, a, o.miss, o.wb, o.timeout, e.miss, e.wb);
            end
            if (e.wb) begin
                n_cmp++;
                if (o.wb_addr !== e.wb_addr || o.wb_data !== e.wb_data || o.wr_cycles !== e.wr_cycles) begin
                    n_err++; $display("FAIL rnd_wb #%0d: addr=%h data=%h cyc=%0d want %h %h %0d", i, o.wb_addr, o.wb_data, o.wr_cycles, e.wb_addr, e.wb_data, e.wr_cycles);
                end
            end
            if (e.miss) begin
                n_cmp++;
                if (o.rd_addr !== e.rd_addr || o.rd_cycles !== e.rd_cycles || o.gaps !== e.gaps) begin
                    n_err++; $display("FAIL rnd_fetch #%0d: addr=%h cyc=%0d gaps=%0d want %h %0d %0d", i, o.rd_addr, o.rd_cycles, o.gaps, e.rd_addr, e.rd_cycles, e.gaps);
                end
            end
            if (!wr) begin
                n_cmp++;
                if (o.rdata !== e.rdata) begin
                    n_err++; $display("FAIL rnd_rdata #%0d a=%h: got %h want %h", i, a, o.rdata, e.rdata);
                end
            end
        end
        for (int b = 0; b < 64; b++) begin
            n_cmp++;
            if (mem[b] !== ref_mem[b]) begin
                n_err++; $display("FAIL rnd_mem[%0d]: got %h want %h", b, mem[b], ref_mem[b]);
            end
        end
    endtask

    task automatic test_stats();
        obs_t o, e;
        int want_h, want_m;
        logic [7:0] a;
        do_reset();
        mem_lat = 1;
        for (int i = 0; i < 3; i++) begin
            a = 8'(i * 4);
            cpu_access(0, a, 8'h00, o); model_access(0, a, 8'h00, e);
        end
        for (int i = 0; i < 300; i++) begin
            a = 8'(($urandom % 3) * 4 + ($urandom % 4));
            cpu_access(0, a, 8'h00, o); model_access(0, a, 8'h00, e);
        end
`ifdef CACHE_STATS_EN
        want_h = exp_hits; want_m = exp_miss;
`else
        want_h = 0; want_m = 0;
`endif
        n_cmp++;
        if (int'(HIT_COUNT) !== want_h || int'(MISS_COUNT) !== want_m) begin
            n_err++; $display("FAIL stats: hit=%0d miss=%0d want %0d %0d", HIT_COUNT, MISS_COUNT, want_h, want_m);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom; ref_mem[i] = mem[i];
        end
        mem[0] = 32'h44332211; ref_mem[0] = 32'h44332211;
        test_reset();
        test_directed();
        test_latency();
        test_reset_midfetch();
        test_random();
        test_stats();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back data cache controller that sits between the CPU's load/store path and the byte-addressable data memory. It holds eight 4-byte blocks with 3-bit tags, resolves hits combinationally with 3-bit tag equality, and stalls the CPU via BUSYWAIT while it sequences write-back and block fetch on misses. Main memory is accessed one 32-bit block at a time through a strobe/busywait handshake.

## Interface
- No parameters. Geometry is fixed at 8 blocks × 4 bytes; address split is tag[7:5], index[4:2], offset[1:0].
- CLK  in  1  system clock; all state updates on rising edge.
- RESETN  in  1  asynchronous, active-low reset.
- READ  in  1  CPU load request, held until BUSYWAIT low.
- WRITE  in  1  CPU store request, held until BUSYWAIT low.
- ADDRESS  in  8  CPU byte address.
- WRITEDATA  in  8  CPU store data.
- READDATA  out  8  load data, valid when READ=1 and BUSYWAIT=0.
- BUSYWAIT  out  1  CPU stall.
- MEM_READ  out  1  block fetch strobe.
- MEM_WRITE  out  1  block write-back strobe.
- MEM_ADDRESS  out  6  block address {tag,index}.
- MEM_WRITEDATA  out  32  write-back block, byte 0 in [7:0].
- MEM_READDATA  in  32  fetched block, byte 0 in [7:0].
- MEM_BUSYWAIT  in  1  memory busy.
- HIT_COUNT  out  8  saturating hit counter (see Configuration).
- MISS_COUNT  out  8  saturating miss counter (see Configuration).

## Operation
- Per block: valid, dirty, tag[2:0], data[31:0].
- HIT = valid[index] & (tag[index] == ADDRESS[7:5]).
- States: IDLE, WRITEBACK, FETCH, UPDATE.
- IDLE, no request: BUSYWAIT=0, no memory strobes.
- IDLE, READ hit: READDATA = selected byte (combinational), BUSYWAIT=0; access completes this cycle.
- IDLE, WRITE hit: BUSYWAIT=0; byte written and dirty set at next edge.
- IDLE, miss: BUSYWAIT=1 combinationally; next state WRITEBACK if valid & dirty, else FETCH.
- WRITEBACK: MEM_WRITE=1, MEM_ADDRESS={stored tag, index}, MEM_WRITEDATA=stored block; go to FETCH when the memory handshake completes.
- FETCH: MEM_READ=1, MEM_ADDRESS=ADDRESS[7:2]; go to UPDATE when the handshake completes.
- UPDATE: strobes low, BUSYWAIT=1. At the edge, the block is loaded from MEM_READDATA, the tag is written, valid=1 and dirty=0. Next state is IDLE, where the pending access re-evaluates as a hit.
- READ and WRITE both high: treated as WRITE.
- ADDRESS and WRITEDATA must stay stable while BUSYWAIT=1. Changes in that window are undefined.

## Timing
- Reset (RESETN low, any state, including mid-transfer): state=IDLE, all valid/dirty=0, MEM_READ=MEM_WRITE=0, BUSYWAIT=0, MEM_ADDRESS=0, MEM_WRITEDATA=0, READDATA=0, counters=0. Tags and data are don't-care.
- Handshake complete: the first rising edge, at least one full cycle after entering WRITEBACK/FETCH, at which MEM_BUSYWAIT=0. MEM_BUSYWAIT is ignored in the entry cycle, which tolerates memories that raise busy one cycle late.
- Clean miss stall = 1 (FETCH entry) + memory latency + 1 (UPDATE) + 1 (IDLE hit) cycles of BUSYWAIT deassertion delay. A dirty miss adds one WRITEBACK handshake.
- Memory strobes are registered-state decodes: glitch-free, constant for the whole state.
- Hit path READDATA/BUSYWAIT is combinational from ADDRESS/READ/WRITE and cache state.

## Configuration
- CACHE_STATS_EN defined: HIT_COUNT increments once per completed access that hit on first evaluation. MISS_COUNT increments once per miss, on the IDLE→WRITEBACK/FETCH transition. Both saturate at 255 and clear on reset. The post-UPDATE re-evaluation is not counted as a hit.
- CACHE_STATS_EN undefined: counters are not built; HIT_COUNT and MISS_COUNT are tied to 0.

## Test plan
- Reset, then READ 0x00 with a memory whose block 0 = 0x44332211 → MEM_READ with MEM_ADDRESS=0x00; after UPDATE, READDATA=0x11, BUSYWAIT low.
- READ 0x03 immediately after → hit: READDATA=0x44, BUSYWAIT stays 0, no memory strobe.
- WRITE 0xAA to 0x01, then READ 0x21 (same index, tag 1) → WRITEBACK with MEM_ADDRESS=0x00 and MEM_WRITEDATA=0x4433AA11, then FETCH with MEM_ADDRESS=0x08.
- Memory busy for 5 cycles → MEM_READ held 6+ cycles, BUSYWAIT high throughout, single UPDATE.
- Assert RESETN low during FETCH → strobes drop immediately; a subsequent READ 0x00 misses again.
- With CACHE_STATS_EN: sequence of 3 misses and 300 hits → MISS_COUNT=3, HIT_COUNT=255. Without it, both read 0.
